// File: rtl/any1_agen_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// any1_agen_sched : round-robin issue scheduler / element sequencer for agen
// Revision 1.0
// ---------------------------------------------------------------------------
module any1_agen_sched #(
  parameter int MAXVL = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic [63:0] inst0_i,
  input  logic [6:0]  vl0_i,
  input  logic        vec0_i,
  input  logic        req1_i,
  input  logic [63:0] inst1_i,
  input  logic [6:0]  vl1_i,
  input  logic        vec1_i,
  input  logic        abort_i,
  input  logic        mrdy_i,
  output logic [1:0]  gnt_o,
  output logic [63:0] inst_o,
  output logic [5:0]  ele_o,
  output logic        tag_o,
  output logic        mav_o,
  output logic        done_o,
  output logic        busy_o
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_fin   = 2'd2;
  localparam logic [6:0] c_maxvl = 7'(MAXVL);

  logic [1:0]  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [63:0] inst_q, inst_d;
  logic [5:0]  ele_q, ele_d;
  logic [5:0]  lastele_q, lastele_d;
  logic        tag_q, tag_d;
  logic        last_q, last_d;
  logic        zero_q, zero_d;
  logic        mav_q, done_q, busy_q;

  logic        w_win;
  logic [6:0]  w_vl;
  logic        w_vec;
  logic [6:0]  w_last7;

  // On a tie the requester that did not win last time gets the grant.
  assign w_win   = (req0_i && req1_i) ? ~last_q : req1_i;
  assign w_vl    = w_win ? vl1_i : vl0_i;
  assign w_vec   = w_win ? vec1_i : vec0_i;
  assign w_last7 = (w_vl > c_maxvl) ? (c_maxvl - 7'd1) : (w_vl - 7'd1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = 2'b00;
    inst_d    = inst_q;
    ele_d     = ele_q;
    lastele_d = lastele_q;
    tag_d     = tag_q;
    last_d    = last_q;
    zero_d    = zero_q;
    case (state_q)
      c_idle: begin
        // A live grant pulse means the winner was latched last edge: launch it.
        if (gnt_q != 2'b00) begin
          state_d = zero_q ? c_fin : c_run;
          ele_d   = 6'd0;
        end else if (req0_i || req1_i) begin
          gnt_d     = w_win ? 2'b10 : 2'b01;
          inst_d    = w_win ? inst1_i : inst0_i;
          tag_d     = w_win;
          last_d    = w_win;
          zero_d    = w_vec && (w_vl == 7'd0);
          lastele_d = w_vec ? w_last7[5:0] : 6'd0;
        end
      end
      c_run: begin
        if (mrdy_i) begin
          if (ele_q == lastele_q) state_d = c_fin;
          else                    ele_d   = ele_q + 6'd1;
        end
      end
      c_fin:   state_d = c_idle;
      default: state_d = c_idle;
    endcase
    if (abort_i) begin
      state_d   = c_idle;
      gnt_d     = 2'b00;
      ele_d     = 6'd0;
      inst_d    = inst_q;
      tag_d     = tag_q;
      last_d    = last_q;
      zero_d    = zero_q;
      lastele_d = lastele_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= c_idle;
      gnt_q     <= 2'b00;
      inst_q    <= 64'd0;
      ele_q     <= 6'd0;
      lastele_q <= 6'd0;
      tag_q     <= 1'b0;
      last_q    <= 1'b1;
      zero_q    <= 1'b0;
      mav_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      inst_q    <= inst_d;
      ele_q     <= ele_d;
      lastele_q <= lastele_d;
      tag_q     <= tag_d;
      last_q    <= last_d;
      zero_q    <= zero_d;
      mav_q     <= (state_d == c_run);
      done_q    <= (state_d == c_fin);
      busy_q    <= (state_d != c_idle);
    end
  end

  assign gnt_o  = gnt_q;
  assign inst_o = inst_q;
  assign ele_o  = ele_q;
  assign tag_o  = tag_q;
  assign mav_o  = mav_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_any1_agen_sched.sv
`default_nettype none
// tb_any1_agen_sched : directed plus randomized bench with a transaction-level model.
module tb_any1_agen_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, vec0 = 1'b0, vec1 = 1'b0;
  logic [63:0] inst0 = '0, inst1 = '0;
  logic [6:0]  vl0 = '0, vl1 = '0;
  logic        abort = 1'b0, mrdy = 1'b0;
  logic [1:0]  gnt_o;
  logic [63:0] inst_o;
  logic [5:0]  ele_o;
  logic        tag_o, mav_o, done_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  any1_agen_sched #(.MAXVL(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .inst0_i(inst0), .vl0_i(vl0), .vec0_i(vec0),
    .req1_i(req1), .inst1_i(inst1), .vl1_i(vl1), .vec1_i(vec1),
    .abort_i(abort), .mrdy_i(mrdy),
    .gnt_o(gnt_o), .inst_o(inst_o), .ele_o(ele_o), .tag_o(tag_o),
    .mav_o(mav_o), .done_o(done_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: one transaction owner, cycles since grant, beats required vs accepted.
  initial begin : model
    int          owner, cyc, total, beats, w, vl;
    logic        vec, last, tag;
    logic [63:0] inst;
    logic [5:0]  ele;
    logic [1:0]  e_gnt;
    logic        e_busy, e_mav, e_done;
    owner = -1; cyc = 0; total = 0; beats = 0;
    last = 1'b1; tag = 1'b0; inst = '0; ele = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        owner = -1; last = 1'b1; inst = '0; tag = 1'b0; ele = '0;
      end else if (abort) begin
        owner = -1; ele = '0;
      end else if (owner < 0) begin
        if (req0 || req1) begin
          w     = (req0 && req1) ? (last ? 0 : 1) : (req1 ? 1 : 0);
          owner = w;
          last  = (w == 1);
          tag   = (w == 1);
          inst  = (w == 1) ? inst1 : inst0;
          vl    = (w == 1) ? int'(vl1) : int'(vl0);
          vec   = (w == 1) ? vec1 : vec0;
          total = !vec ? 1 : ((vl > 64) ? 64 : vl);
          beats = 0;
          cyc   = 0;
        end
      end else if (cyc == 0) begin
        cyc = 1; ele = '0;
      end else if (beats < total) begin
        if (mrdy) begin
          beats++;
          if (beats < total) ele = 6'(beats);
        end
      end else begin
        owner = -1;
      end
      #1;
      e_gnt  = (owner >= 0 && cyc == 0) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_busy = (owner >= 0 && cyc >= 1);
      e_mav  = e_busy && (beats < total);
      e_done = e_busy && (beats == total);
      chk("m_gnt", gnt_o, e_gnt);
      chk("m_busy", busy_o, e_busy);
      chk("m_mav", mav_o, e_mav);
      chk("m_done", done_o, e_done);
      chk("m_inst", inst_o, inst);
      chk("m_tag", tag_o, tag);
      chk("m_ele", ele_o, ele);
    end
  end

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) begin
        g = gnt_o;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_gnt: got timeout expected grant");
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy_o && gnt_o == 2'b00) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle: got timeout expected idle");
  endtask

  task automatic wait_ele(input logic [5:0] e);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mav_o && ele_o == e) return;
    end
    checks++; errors++;
    $display("FAIL wait_ele: got timeout expected ele %0d", e);
  endtask

  initial begin : stim
    logic [1:0] g;
    logic       pat [6];
    int         seq [6];
    int         n, beats;
    logic [5:0] le;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    seq = '{0, 1, 1, 2, 3, 3};

    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt_o, 0); chk("rst_mav", mav_o, 0);
    chk("rst_busy", busy_o, 0); chk("rst_ele", ele_o, 0);
    chk("rst_inst", inst_o, 0); chk("rst_done", done_o, 0);
    rst = 1'b0;

    // Scalar from requester 0
    req0 = 1'b1; inst0 = 64'h1234; vec0 = 1'b0; mrdy = 1'b1;
    @(negedge clk); chk("t1_gnt", gnt_o, 2'b01); req0 = 1'b0;
    @(negedge clk); chk("t1_mav", mav_o, 1); chk("t1_ele", ele_o, 0); chk("t1_inst", inst_o, 64'h1234);
    @(negedge clk); chk("t1_done", done_o, 1); chk("t1_mav_off", mav_o, 0);
    @(negedge clk); chk("t1_busy", busy_o, 0); chk("t1_done_off", done_o, 0);

    // Vector vl=4 from requester 1 with stalls
    req1 = 1'b1; inst1 = 64'hABCD_0000_5555; vl1 = 7'd4; vec1 = 1'b1;
    wait_gnt(g); chk("t2_gnt", g, 2'b10); req1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("t2_mav", mav_o, 1); chk("t2_ele", ele_o, 6'(seq[i])); chk("t2_tag", tag_o, 1);
      mrdy = pat[i];
      @(negedge clk);
    end
    chk("t2_done", done_o, 1); chk("t2_mav_off", mav_o, 0);
    @(negedge clk); chk("t2_done_once", done_o, 0);
    mrdy = 1'b1;

    // Both requesters held after reset: grants alternate starting with 0
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; vec0 = 1'b0; vec1 = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) begin
        chk($sformatf("t3_alt%0d", n), gnt_o, (n % 2 == 1) ? 2'b10 : 2'b01);
        n++;
      end
    end
    if (n < 4) begin checks++; errors++; $display("FAIL t3_alt: got %0d grants expected 4", n); end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // vl=0: grant then done, no address
    req0 = 1'b1; vec0 = 1'b1; vl0 = 7'd0;
    wait_gnt(g); chk("t4_gnt", g, 2'b01); chk("t4_mav_g", mav_o, 0); req0 = 1'b0;
    @(negedge clk); chk("t4_done", done_o, 1); chk("t4_mav", mav_o, 0);
    wait_idle();

    // vl=100 clamps to 64 beats
    req1 = 1'b1; vec1 = 1'b1; vl1 = 7'd100;
    wait_gnt(g); req1 = 1'b0;
    beats = 0; le = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mav_o) begin beats++; le = ele_o; end
      if (done_o) break;
    end
    chk("t4_beats", beats, 64); chk("t4_lastele", le, 63);
    wait_idle();

    // Abort mid-vector at ele 3, then both pending: req1 wins (req0 went last)
    req0 = 1'b1; vec0 = 1'b1; vl0 = 7'd8;
    wait_gnt(g); chk("t5_gnt", g, 2'b01); req0 = 1'b0;
    wait_ele(6'd3);
    abort = 1'b1; req0 = 1'b1; vec0 = 1'b0; req1 = 1'b1; vec1 = 1'b0;
    @(negedge clk);
    chk("t5_mav", mav_o, 0); chk("t5_done", done_o, 0); chk("t5_busy", busy_o, 0);
    chk("t5_ele", ele_o, 0); chk("t5_gnt0", gnt_o, 0);
    abort = 1'b0;
    wait_gnt(g); chk("t5_next", g, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // Reset mid-vector at ele 5, then req0 wins the tie
    req1 = 1'b1; vec1 = 1'b1; vl1 = 7'd8;
    wait_gnt(g); req1 = 1'b0;
    wait_ele(6'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_gnt", gnt_o, 0); chk("t6_mav", mav_o, 0); chk("t6_done", done_o, 0);
    chk("t6_busy", busy_o, 0); chk("t6_ele", ele_o, 0); chk("t6_inst", inst_o, 0); chk("t6_tag", tag_o, 0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    wait_gnt(g); chk("t6_next", g, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req0 && gnt_o[0]) req0 = 1'b0;
      if (req1 && gnt_o[1]) req1 = 1'b0;
      if (!req0 && $urandom_range(3) == 0) begin
        req0 = 1'b1; inst0 = {$urandom, $urandom}; vec0 = 1'($urandom_range(1));
        vl0 = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(6));
      end
      if (!req1 && $urandom_range(3) == 0) begin
        req1 = 1'b1; inst1 = {$urandom, $urandom}; vec1 = 1'($urandom_range(1));
        vl1 = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(6));
      end
      mrdy  = ($urandom_range(3) != 0);
      abort = ($urandom_range(60) == 0);
    end
    req0 = 1'b0; req1 = 1'b0; abort = 1'b0; mrdy = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
